// File: rtl/csr_counter_access_pkg.sv
// Shared CSR constants for the counter access block: data width, address map
// and mcountinhibit bit positions.
package csr_counter_access_pkg;

  localparam int CSR_XLEN = 32;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  localparam int MCI_CY = 0;
  localparam int MCI_IR = 2;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
// A write to either half takes priority over the increment in that cycle.
module csr_counter64
  import csr_counter_access_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                wr_lo,
  input  logic                wr_hi,
  input  logic [CSR_XLEN-1:0] wdata,
  output logic [63:0]         value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_counter_access.sv
// CSR front end for mcycle/minstret/mcountinhibit: decodes one access per
// cycle, answers it one cycle later, and steers writes into the counters.
module csr_counter_access
  import csr_counter_access_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cyc_inc_i,
  input  logic            ret_inc_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ack_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o
);

  logic [63:0]     mcycle;
  logic [63:0]     minstret;
  logic [2:0]      inhibit;
  logic [XLEN-1:0] rd_val;
  logic            unmapped, read_only, fault, wen;
  logic            sel_cyc_lo, sel_cyc_hi, sel_ret_lo, sel_ret_hi, sel_inh;

  always_comb begin
    rd_val     = '0;
    unmapped   = 1'b0;
    read_only  = 1'b0;
    sel_cyc_lo = 1'b0;
    sel_cyc_hi = 1'b0;
    sel_ret_lo = 1'b0;
    sel_ret_hi = 1'b0;
    sel_inh    = 1'b0;
    case (addr_i)
      CSR_MCYCLE:        begin rd_val = mcycle[31:0];    sel_cyc_lo = 1'b1; end
      CSR_MCYCLEH:       begin rd_val = mcycle[63:32];   sel_cyc_hi = 1'b1; end
      CSR_MINSTRET:      begin rd_val = minstret[31:0];  sel_ret_lo = 1'b1; end
      CSR_MINSTRETH:     begin rd_val = minstret[63:32]; sel_ret_hi = 1'b1; end
      CSR_MCOUNTINHIBIT: begin rd_val = {{(XLEN-3){1'b0}}, inhibit}; sel_inh = 1'b1; end
      CSR_CYCLE:         begin rd_val = mcycle[31:0];    read_only = 1'b1; end
      CSR_CYCLEH:        begin rd_val = mcycle[63:32];   read_only = 1'b1; end
      CSR_INSTRET:       begin rd_val = minstret[31:0];  read_only = 1'b1; end
      CSR_INSTRETH:      begin rd_val = minstret[63:32]; read_only = 1'b1; end
      default:           unmapped = 1'b1;
    endcase
  end

  assign fault = unmapped | (we_i & read_only);
  assign wen   = req_i & we_i & ~fault;

  // Inhibit bits take effect from the cycle after the write; the counters see
  // the old value during the write cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit <= '0;
    end else if (wen && sel_inh) begin
      inhibit <= {wdata_i[MCI_IR], 1'b0, wdata_i[MCI_CY]};
    end
  end

  // Faulting or idle cycles return zero data so the bus never sees stale values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o   <= req_i;
      err_o   <= req_i & fault;
      rdata_o <= (req_i && !fault) ? rd_val : '0;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (cyc_inc_i & ~inhibit[MCI_CY]),
    .wr_lo (wen & sel_cyc_lo),
    .wr_hi (wen & sel_cyc_hi),
    .wdata (wdata_i),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (ret_inc_i & ~inhibit[MCI_IR]),
    .wr_lo (wen & sel_ret_lo),
    .wr_hi (wen & sel_ret_hi),
    .wdata (wdata_i),
    .value (minstret)
  );

endmodule

// File: tb/tb_csr_counter_access.sv
// Scoreboard bench for csr_counter_access: stimulus pushes hand-computed
// responses, a negedge monitor pops and compares them when ack_o is seen.
module tb_csr_counter_access;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_inc_i = 1'b0;
  logic        ret_inc_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  exp_t expQ[$];
  logic expAck = 1'b0;
  int   errors = 0;
  int   checks = 0;

  csr_counter_access #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cyc_inc_i (cyc_inc_i),
    .ret_inc_i (ret_inc_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .ack_o     (ack_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // Independent model of the one-cycle acknowledge.
  always @(posedge clk) expAck <= req_i && !rst;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compares acknowledge timing every cycle and pops the scoreboard on ack.
  always @(negedge clk) begin
    if (ack_o !== expAck || expAck) checkOutput("ack", {31'b0, ack_o}, {31'b0, expAck});
    if (ack_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({e.name, "_err"}, {31'b0, err_o}, {31'b0, e.err});
        if (e.chk_data) checkOutput({e.name, "_rdata"}, rdata_o, e.rdata);
      end
    end else if (rdata_o !== '0 || err_o !== 1'b0) begin
      checkOutput("idle_rdata", rdata_o, 32'd0);
      checkOutput("idle_err", {31'b0, err_o}, 32'd0);
    end
  end

  task automatic applyStimulus(input string name, input logic r, input logic req,
                               input logic we, input logic [11:0] addr, input logic [31:0] wd,
                               input logic cyc, input logic ret,
                               input logic [31:0] expRdata, input logic expErr, input logic chk);
    @(posedge clk);
    #1;
    rst       = r;
    req_i     = req;
    we_i      = we;
    addr_i    = addr;
    wdata_i   = wd;
    cyc_inc_i = cyc;
    ret_inc_i = ret;
    if (req && !r) begin
      exp_t e;
      e.rdata    = expRdata;
      e.err      = expErr;
      e.chk_data = chk;
      e.name     = name;
      expQ.push_back(e);
    end
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] expv);
    applyStimulus(name, 1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b0, expv, 1'b0, 1'b1);
  endtask

  task automatic wr(input string name, input logic [11:0] addr, input logic [31:0] wd,
                    input logic cyc, input logic ret);
    applyStimulus(name, 1'b0, 1'b1, 1'b1, addr, wd, cyc, ret, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic cyc, input logic ret);
    for (int i = 0; i < n; i++)
      applyStimulus("idle", 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, cyc, ret, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", {31'b0, ack_o}, 32'd0);
    checkOutput("reset_rdata", rdata_o, 32'd0);
    checkOutput("reset_err", {31'b0, err_o}, 32'd0);

    // Ten counted cycles, then reads; a read during an event sees the old value.
    applyStimulus("rel", 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(9, 1'b1, 1'b0);
    rd("mcycle10", 12'hB00, 32'd10);
    rd("mcycleh0", 12'hB80, 32'd0);
    rd("minstret0", 12'hB02, 32'd0);
    applyStimulus("cycle_pre", 1'b0, 1'b1, 1'b0, 12'hC00, 32'h0, 1'b1, 1'b0, 32'd10, 1'b0, 1'b1);
    rd("mcycle11", 12'hB00, 32'd11);

    // Carry from low into high half.
    wr("wr_lo_max", 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr("wr_hi_0", 12'hB80, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    rd("carry_lo", 12'hB00, 32'd0);
    rd("carry_hi", 12'hB80, 32'd1);
    rd("carry_alias", 12'hC80, 32'd1);

    // Write wins over a coincident increment.
    wr("wr_ret5", 12'hB02, 32'd5, 1'b0, 1'b1);
    rd("minstret5", 12'hB02, 32'd5);
    rd("minstreth0", 12'hB82, 32'd0);

    // Inhibit CY: write cycle still counts both, then only minstret counts.
    wr("wr_inh1", 12'h320, 32'h1, 1'b1, 1'b1);
    idle(20, 1'b1, 1'b1);
    rd("inh_rd", 12'h320, 32'h1);
    rd("inh_cyc_lo", 12'hB00, 32'd1);
    rd("inh_cyc_hi", 12'hB80, 32'd1);
    rd("inh_ret", 12'hB02, 32'd26);
    wr("wr_inh7", 12'h320, 32'h7, 1'b0, 1'b0);
    rd("inh_bit1", 12'h320, 32'h5);
    idle(3, 1'b1, 1'b1);
    rd("inh_both_ret", 12'hC02, 32'd26);
    rd("inh_both_cyc", 12'hC00, 32'd1);
    wr("wr_inh0", 12'h320, 32'h0, 1'b0, 1'b0);

    // Faults: read-only alias write and unmapped read.
    applyStimulus("ro_write", 1'b0, 1'b1, 1'b1, 12'hC00, 32'h1234, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus("unmapped", 1'b0, 1'b1, 1'b0, 12'h7FF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    rd("fault_cyc", 12'hB00, 32'd1);
    rd("fault_ret", 12'hB02, 32'd26);

    // 64-bit wrap of both counters on one simultaneous event.
    wr("max_cl", 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr("max_ch", 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr("max_rl", 12'hB02, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr("max_rh", 12'hB82, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b1);
    rd("wrap_cl", 12'hB00, 32'd0);
    rd("wrap_ch", 12'hB80, 32'd0);
    rd("wrap_rl", 12'hB02, 32'd0);
    rd("wrap_rh", 12'hB82, 32'd0);

    // Reset with a pending request and events: dropped, counters cleared.
    idle(3, 1'b1, 1'b1);
    applyStimulus("rst_req", 1'b1, 1'b1, 1'b0, 12'hB00, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus("post_rst", 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rd("rst_cyc", 12'hB00, 32'd0);
    rd("rst_ret", 12'hC02, 32'd0);
    idle(1, 1'b1, 1'b0);
    rd("resume_cyc", 12'hB00, 32'd1);
    idle(3, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_counter_access.md
CSR_COUNTER_ACCESS -- requirements
Module: csr_counter_access

Interface
REQ-001 SHALL have parameter XLEN, default 32 (`CSR_XLEN`), the CSR data width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cyc_inc_i  input  1  cycle event; increments mcycle when not inhibited.
REQ-005 SHALL have port ret_inc_i  input  1  instruction-retired event; increments minstret when not inhibited.
REQ-006 SHALL have port req_i  input  1  CSR access request, one access per asserted cycle.
REQ-007 SHALL have port we_i  input  1  write (1) or read (0), sampled with req_i.
REQ-008 SHALL have port addr_i  input  12  CSR address, sampled with req_i.
REQ-009 SHALL have port wdata_i  input  XLEN  write data, sampled with req_i.
REQ-010 SHALL have port ack_o  output  1  response valid.
REQ-011 SHALL have port rdata_o  output  XLEN  read data, valid when ack_o=1.
REQ-012 SHALL have port err_o  output  1  access fault, valid when ack_o=1.

Function
REQ-013 SHALL hold two 64-bit counters, mcycle and minstret, and a 3-bit mcountinhibit register (bit0 CY, bit2 IR, bit1 reads 0).
REQ-014 SHALL decode: 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi, 0x320 mcountinhibit (read/write); 0xC00/0xC80 cycle lo/hi, 0xC02/0xC82 instret lo/hi (read-only aliases).
REQ-015 SHALL accept a request every cycle with no back-pressure; ack_o SHALL equal req_i delayed one cycle.
REQ-016 SHALL register rdata_o from the counter value present in the request cycle (before that cycle's increment).
REQ-017 SHALL assert err_o with ack_o for an unmapped address or a write to a read-only alias; such a write SHALL change no state; rdata_o SHALL be 0.
REQ-018 SHALL drive rdata_o=0 and err_o=0 whenever ack_o=0.
REQ-019 SHALL increment each counter by exactly 1 per event cycle as a full 64-bit add; carry from low into high half in the same cycle.
REQ-020 SHALL wrap 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-021 SHALL suppress increments while the matching mcountinhibit bit is 1.
REQ-022 SHALL, on a write to a counter half coinciding with its increment event, store wdata_i in that half, leave the other half unchanged and suppress that cycle's increment (write wins, no carry).
REQ-023 SHALL apply an mcountinhibit write from the following cycle; the increment in the write cycle follows the old value.
REQ-024 SHALL treat simultaneous cyc_inc_i and ret_inc_i independently.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear mcycle, minstret, mcountinhibit, ack_o, rdata_o and err_o to 0.
REQ-026 SHALL drop a request presented in a reset cycle: no ack, no state change.
REQ-027 SHALL ignore increment events in reset cycles; counting resumes the first cycle with rst=0.

Structure
REQ-028 SHALL take CSR address constants, XLEN and mcountinhibit bit indices from the shared defines file, not local literals.
REQ-029 SHALL implement each counter as one instance of sub-module csr_counter64 (64-bit value, inc, write-lo, write-hi, write data); two instances.
REQ-030 SHALL keep address decode, response register and mcountinhibit in csr_counter_access.

Verification
REQ-031 SHALL cover: reset, then 10 cycles with cyc_inc_i=1, read 0xB00 -> ack_o next cycle, rdata_o=10, err_o=0.
REQ-032 SHALL cover: write 0xB00=0xFFFF_FFFF and 0xB80=0, then one cyc_inc_i -> read 0xB00=0, 0xB80=1.
REQ-033 SHALL cover: write 0xB02=5 in a cycle with ret_inc_i=1 -> read 0xB02=5 (increment suppressed).
REQ-034 SHALL cover: write 0x320=0x1, 20 cycles with cyc_inc_i=1 and ret_inc_i=1 -> mcycle unchanged, minstret +20 (with the write cycle counted per REQ-023).
REQ-035 SHALL cover: write 0xC00 and read 0x7FF -> err_o=1 each, rdata_o=0, counters unchanged.
REQ-036 SHALL cover: counters at 0xFFFF_FFFF_FFFF_FFFF, one event -> 0; rst asserted with req_i=1 -> no ack, all outputs 0.
